// File: rtl/ninjakun_busarb.sv
// Clock-enable generator and shared I/O bus arbiter for the two Z80 cores.
// A CPU requesting the bus while the other owns it loses its enable slots until granted.
module ninjakun_busarb #(
    parameter int PHASE_LEN = 4
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        CP1EN,
    input  logic        CP0REQ,
    input  logic        CP1REQ,
    input  logic [15:0] CP0AD,
    input  logic [15:0] CP1AD,
    input  logic [7:0]  CP0OD,
    input  logic [7:0]  CP1OD,
    input  logic        CP0RD,
    input  logic        CP1RD,
    input  logic        CP0WR,
    input  logic        CP1WR,
    input  logic [7:0]  CPIDT,
    output logic        CP0CE_P,
    output logic        CP0CE_N,
    output logic        CP1CE_P,
    output logic        CP1CE_N,
    output logic [7:0]  CP0ID,
    output logic [7:0]  CP1ID,
    output logic [15:0] CPADR,
    output logic [7:0]  CPODT,
    output logic        CPRED,
    output logic        CPWRT,
    output logic        CPSEL,
    output logic        CP0WAIT,
    output logic        CP1WAIT
);

    localparam int PERIOD = 2 * PHASE_LEN;
    localparam int CW     = $clog2(PERIOD);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t         state_q, state_d;
    logic           pri_q, pri_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    adr_q, adr_d;
    logic [7:0]     odt_q, odt_d;
    logic           red_q, red_d;
    logic           wrt_q, wrt_d;
    logic           sel_q, sel_d;
    logic [7:0]     id0_q, id0_d;
    logic [7:0]     id1_q, id1_d;

    logic req0, req1, grant0, grant1, stall0, stall1;
    logic slot_first, slot_mid, slot_last;

    // CPU1 requests are invisible when the core is absent.
    assign req0   = CP0REQ;
    assign req1   = CP1REQ & CP1EN;
    assign grant0 = (state_q == OWN0);
    assign grant1 = (state_q == OWN1);
    assign stall0 = req0 & ~grant0;
    assign stall1 = req1 & ~grant1;

    assign slot_first = (cnt_q == CW'(0));
    assign slot_mid   = (cnt_q == CW'(PHASE_LEN));
    assign slot_last  = (cnt_q == CW'(PERIOD - 1));

    // RESET gates the enables directly so no pulse escapes while cnt sits at 0.
    assign CP0CE_P = ~RESET & slot_first & ~stall0;
    assign CP0CE_N = ~RESET & slot_mid   & ~stall0;
    assign CP1CE_P = ~RESET & CP1EN & slot_mid  & ~stall1;
    assign CP1CE_N = ~RESET & CP1EN & slot_last & ~stall1;
    assign CP0WAIT = stall0;
    assign CP1WAIT = stall1;

    assign CPADR = adr_q;
    assign CPODT = odt_q;
    assign CPRED = red_q;
    assign CPWRT = wrt_q;
    assign CPSEL = sel_q;
    assign CP0ID = id0_q;
    assign CP1ID = id1_q;

    assign cnt_d = slot_last ? '0 : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = pri_q ? OWN1 : OWN0;
                    pri_d   = ~pri_q;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: if (!req0) state_d = req1 ? OWN1 : IDLE;
            OWN1: if (!req1) state_d = req0 ? OWN0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus mux lags the grant by one MCLK; IDLE keeps address/data/select parked.
    always_comb begin
        adr_d = adr_q;
        odt_d = odt_q;
        red_d = 1'b0;
        wrt_d = 1'b0;
        sel_d = sel_q;
        case (state_q)
            OWN0: begin
                adr_d = CP0AD;
                odt_d = CP0OD;
                red_d = CP0RD;
                wrt_d = CP0WR;
                sel_d = 1'b0;
            end
            OWN1: begin
                adr_d = CP1AD;
                odt_d = CP1OD;
                red_d = CP1RD;
                wrt_d = CP1WR;
                sel_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Read data is only captured when the strobe on the bus belongs to the owner.
    assign id0_d = (grant0 && red_q && !sel_q) ? CPIDT : id0_q;
    assign id1_d = (grant1 && red_q &&  sel_q) ? CPIDT : id1_q;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            pri_q   <= 1'b0;
            adr_q   <= 16'h0000;
            odt_q   <= 8'h00;
            red_q   <= 1'b0;
            wrt_q   <= 1'b0;
            sel_q   <= 1'b0;
            id0_q   <= 8'hFF;
            id1_q   <= 8'hFF;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pri_q   <= pri_d;
            adr_q   <= adr_d;
            odt_q   <= odt_d;
            red_q   <= red_d;
            wrt_q   <= wrt_d;
            sel_q   <= sel_d;
            id0_q   <= id0_d;
            id1_q   <= id1_d;
        end
    end

endmodule
